// File: rtl/encoder_8to3_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8to3_seq_if
// Description : Request-vector in / index out handshake bundle for the
//               sequential 8-to-3 encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface encoder_8to3_seq_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic             in_valid;
    logic [WIDTH-1:0] in_vec;
    logic             in_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_ready;
    logic             zero_drop;

    // master: request source plus index consumer; slave: the encoder
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, zero_drop
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, zero_drop
    );
endinterface
`default_nettype wire

// File: rtl/encoder_8to3_seq.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8to3_seq
// Description : Serialises a multi-hot request vector into binary indices,
//               lowest set bit first, one index per output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8to3_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    encoder_8to3_seq_if.slave      bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic             zero_drop_q;
    logic             zero_drop_d;

    state_t           w_state;
    logic [IDX_W-1:0] w_lowest_idx;
    logic             w_single;
    logic             w_out_valid;
    logic             w_out_last;
    logic             w_out_fire;
    logic             w_in_ready;
    logic             w_in_fire;

    always_comb begin
        w_state      = (pending_q == '0) ? IDLE : SERVE;

        // Scan downwards so the lowest set bit is the final assignment
        w_lowest_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_lowest_idx = IDX_W'(i);
            end
        end

        w_single     = (w_state == SERVE) &&
                       ((pending_q & (pending_q - WIDTH'(1))) == '0);
        w_out_valid  = en && (w_state == SERVE);
        w_out_last   = w_out_valid && w_single;
        w_out_fire   = w_out_valid && bus.out_ready;
        // Accepting on the last index keeps back-to-back vectors bubble-free
        w_in_ready   = en && !rst && ((w_state == IDLE) || (w_out_fire && w_out_last));
        w_in_fire    = bus.in_valid && w_in_ready;

        pending_d    = pending_q;
        if (w_in_fire) begin
            pending_d = bus.in_vec;
        end else if (w_out_fire) begin
            pending_d = pending_q & ~(WIDTH'(1) << w_lowest_idx);
        end

        zero_drop_d  = w_in_fire && (bus.in_vec == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = w_lowest_idx;
    assign bus.out_last  = w_out_last;
    assign bus.zero_drop = zero_drop_q;

endmodule
`default_nettype wire

// File: doc/encoder_8to3_seq.md
Name: encoder_8to3_seq

Overview:
- Sequential counterpart of the team's 3-to-8 one-hot decoder: accepts a multi-hot request vector and emits the binary index of each set bit, one index per handshake, lowest index first.
- Bit k of the input vector maps to index k, so `decoder(out_idx)` reproduces the one-hot of the bit currently served.
- Sits between request sources (interrupt and event lines) and index-driven consumers, such as a downstream 3-to-8 decoder or a register-file select.

Parameters:
- WIDTH, 8, request vector width.
- IDX_W, 3, index width; must equal clog2(WIDTH). Out-of-range values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  block enable; 0 stalls both interfaces and holds all state
- in_valid  input  1  request vector valid
- in_vec  input  WIDTH  multi-hot request vector
- in_ready  output  1  block can accept in_vec this cycle
- out_valid  output  1  out_idx is valid
- out_idx  output  IDX_W  index of lowest set pending bit
- out_last  output  1  out_idx is the final pending bit of the current vector
- out_ready  input  1  consumer accepts out_idx
- zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded

Behaviour:
- Internal state:
  - pending register, WIDTH bits.
  - Two states, derived: IDLE when pending==0, SERVE when pending!=0.
- Reset (async, rst=1):
  - pending=0, zero_drop=0.
  - Therefore out_valid=0, out_idx=0, out_last=0.
  - in_ready=0 while rst is asserted.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- in_ready = en & (pending==0 | (out_fire & out_last)). Back-to-back vectors therefore lose no cycle.
- Outputs (combinational from pending):
  - out_valid = en & (pending!=0).
  - out_idx = index of lowest set bit of pending; 0 when pending==0.
  - out_last = out_valid & (exactly one bit of pending set).
- Output signals are stable while out_valid=1 and out_ready=0. The source may drop in_valid freely. Neither side waits on the other combinationally (out_ready does not depend on in_valid).
- Next-state rules:
  - If in_fire: pending <= in_vec. This covers the simultaneous out_fire & out_last case, where the load wins.
  - Else if out_fire: pending <= pending with bit out_idx cleared.
  - Else: pending holds.
- Latency:
  - Vector accepted at edge N gives first out_valid in the cycle after edge N.
  - One index per cycle while out_ready=1.
  - A vector with p set bits drains in p out_fire cycles.
- Zero vector:
  - in_fire with in_vec==0 is accepted, pending stays 0 (state remains IDLE), and zero_drop=1 for exactly the next cycle.
  - zero_drop is a registered pulse, cleared the following cycle unless another zero vector fires.
- en=0:
  - out_valid=0 and in_ready=0, so no fire events occur.
  - pending is held, and zero_drop is cleared on the next edge.
  - On returning to en=1, serving resumes at the same index.
- Reset mid-operation: pending is discarded immediately and the block returns to IDLE. No partial indices are emitted after reset.
- All-ones vector (8'hFF): indices 0..7 in ascending order; out_last=1 only with index 7.

Test Plan:
- Reset, then in_vec=8'b1010_0100 with in_valid=1 and out_ready=1 held → out_idx 2,5,7 on consecutive cycles, out_last=1 only at idx 7, then out_valid=0.
- out_ready=0 for 3 cycles while pending=8'b0001_1000 → out_valid=1 and out_idx=3 stable for all 3 cycles; after out_ready=1, idx 3 then 4.
- Back-to-back: vector 8'h01 then 8'h80 presented continuously → idx 0 (last) and new load on the same edge; idx 7 appears the next cycle with no bubble.
- in_vec=8'h00 accepted → zero_drop=1 for one cycle, out_valid stays 0, in_ready stays 1.
- en=0 asserted after the first index of 8'hFF is served → out_valid=0 and in_ready=0; after en=1, sequence resumes at idx 1 through idx 7.
- rst pulsed asynchronously mid-way through 8'hF0 (after idx 4) → out_valid=0 immediately, pending=0; afterwards, new vector 8'h02 yields only idx 1.
